// File: rtl/mux_pkg.sv
// Shared state type and channel-increment helper for the registered N-channel multiplexer.
package mux_pkg;

    typedef enum logic {S_DIRECT, S_SCAN} state_e;

    // Modulo increment; an out-of-range current value restarts at channel 0.
    function automatic int unsigned next_ch(input int unsigned cur, input int unsigned channels);
        return (cur + 32'd1 >= channels) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/rr_next.sv
// Next-set-bit finder with wrap: returns the lowest enabled channel above cur,
// else the lowest enabled channel overall.
module rr_next
    import mux_pkg::*;
#(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    nxt,
    output logic                found
);

    logic [SEL_W-1:0] lo;
    logic [SEL_W-1:0] hi;
    logic             hi_found;

    always_comb begin
        lo       = '0;
        hi       = '0;
        hi_found = 1'b0;
        // Descending scan so the last hit is the lowest qualifying index.
        for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lo = SEL_W'(k);
                if (k > int'(cur)) begin
                    hi       = SEL_W'(k);
                    hi_found = 1'b1;
                end
            end
        end
        nxt   = hi_found ? hi : lo;
        found = |mask;
    end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-channel multiplexer with valid/ready handshake and round-robin scan mode.
// Optional channel masking is enabled by defining MUX_N_REG_MASK_EN (adds the ch_mask port).
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      scan,
`ifdef MUX_N_REG_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_err
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             out_err_q, out_err_d;

    logic             accept;
    logic             ch_ok;
    logic             lanes_ok;
    logic [SEL_W-1:0] ch;
    logic [SEL_W-1:0] ch_succ;
    logic [WIDTH-1:0] ch_data;

    assign ch = ((state_q == S_SCAN) && scan) ? cnt_q : sel;

`ifdef MUX_N_REG_MASK_EN
    logic mask_any;

    rr_next #(
        .CHANNELS(CHANNELS),
        .SEL_W   (SEL_W)
    ) u_rr_next (
        .mask (ch_mask),
        .cur  (ch),
        .nxt  (ch_succ),
        .found(mask_any)
    );

    // An empty mask stalls scan mode only; direct mode still completes with an error.
    assign lanes_ok = mask_any || (state_q != S_SCAN);
`else
    assign ch_succ  = SEL_W'(next_ch(32'(ch), CHANNELS));
    assign lanes_ok = 1'b1;
`endif

    always_comb begin
        ch_data = '0;
        ch_ok   = 1'b0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (ch == SEL_W'(k)) begin
                ch_data = in[k*WIDTH +: WIDTH];
`ifdef MUX_N_REG_MASK_EN
                ch_ok   = ch_mask[k];
`else
                ch_ok   = 1'b1;
`endif
            end
        end
    end

    assign in_ready = (!out_valid_q || out_ready) && lanes_ok;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            out_d       = ch_ok ? ch_data : '0;
            out_ch_d    = ch;
            out_err_d   = !ch_ok;
            out_valid_d = 1'b1;
            if (scan) begin
                state_d = S_SCAN;
                cnt_d   = ch_succ;
            end else begin
                state_d = S_DIRECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DIRECT;
            cnt_q       <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output stage and a valid/ready handshake.
- Two selection modes:
  - direct mode: the channel comes from `sel`.
  - scan mode: an internal counter steps through the channels round-robin.
- Sits between parallel register/data sources and a single consumer, such as the ALU operand path or a debug/trace port.

Parameters:
- `WIDTH`, 16, bits per channel.
- `CHANNELS`, 16, number of input channels, ≥2; need not be a power of 2.
- `SEL_W`, `$clog2(CHANNELS)`, select width; derived, not to be overridden.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in` input `CHANNELS*WIDTH`: flattened channels; channel k = `in[k*WIDTH +: WIDTH]`.
- `sel` input `SEL_W`: direct-mode channel; also the scan start channel.
- `scan` input 1: 0 = direct mode, 1 = scan mode.
- `in_valid` input 1: request a transfer this cycle.
- `in_ready` output 1: stage can accept.
- `out` output `WIDTH`: registered selected data.
- `out_ch` output `SEL_W`: channel index that produced `out`.
- `out_valid` output 1: `out`/`out_ch`/`out_err` hold a transfer.
- `out_ready` input 1: consumer accepts.
- `out_err` output 1: the held transfer had an out-of-range select.

Behaviour:
- Reset (async, `rst_n`=0): `out`=0, `out_ch`=0, `out_valid`=0, `out_err`=0, scan counter=0, FSM=S_DIRECT. Release takes effect on the next `clk` edge.
- `in_ready` = `!out_valid || out_ready` (combinational). Accept = `in_valid && in_ready`.
- On accept, next edge:
  - `out` ← channel `ch`.
  - `out_ch` ← `ch`.
  - `out_valid` ← 1.
  - `out_err` ← (`ch` ≥ `CHANNELS`).
  - Latency is one cycle from accept to `out_valid`.
- On `out_valid && out_ready && !in_valid`: `out_valid` ← 0. `out`, `out_ch` and `out_err` hold their last value.
- Simultaneous drain and accept: `out_valid` stays 1 and new data loads. Full throughput is one transfer per cycle.
- While `out_valid && !out_ready`: `out`, `out_ch` and `out_err` are stable, and `in` changes are ignored.
- FSM states:
  - S_DIRECT: `ch` = `sel`.
  - S_SCAN: `ch` = scan counter.
- FSM transitions are evaluated only on accept:
  - S_DIRECT with `scan`=1: this accept uses `sel`, counter ← `sel`+1 (wrapped), go to S_SCAN.
  - S_SCAN with `scan`=1: use counter, counter ← counter+1 (wrapped).
  - S_SCAN with `scan`=0: this accept uses `sel`, go to S_DIRECT.
  - No accept: state and counter hold.
- Wrap: counter increments modulo `CHANNELS`, so `CHANNELS`-1 → 0. An out-of-range `sel` used as the scan start gives counter=0.
- Out of range (`sel` ≥ `CHANNELS`, direct mode): `out` ← 0 and `out_err` ← 1; the transfer still completes.
- Reset mid-transfer: the pending output is dropped and `out_valid`=0 immediately.

Optional Feature:
- Macro: `MUX_N_REG_MASK_EN`.
- Defined:
  - Adds input port `ch_mask` [`CHANNELS`-1:0].
  - Scan mode skips masked-off channels: the next counter value is the next set bit above the current one, wrapping.
  - If the mask is all-zero in S_SCAN: `in_ready`=0 and no accept occurs.
  - Direct mode with a masked-off `sel`: `out` ← 0 and `out_err` ← 1.
- Undefined: no port; all channels are enabled.

Decomposition:
- Shared package `mux_pkg`:
  - state enum {S_DIRECT, S_SCAN}.
  - function `next_ch(cur, CHANNELS)` for the modulo increment.
- One sub-module, `rr_next`: combinational next-set-bit finder with wrap, instantiated only under `MUX_N_REG_MASK_EN`.

Test Plan:
1. WIDTH=16, CHANNELS=16; channel k = 16'hA000+k; direct mode, `sel`=5, `in_valid`=1, `out_ready`=1 → next cycle `out`=16'hA005, `out_ch`=5, `out_valid`=1, `out_err`=0.
2. CHANNELS=5, `scan`=1, `sel`=3, `in_valid` held with `out_ready`=1 for 6 cycles → `out_ch` sequence 3,4,0,1,2,3.
3. Backpressure: `out_ready`=0 for 4 cycles while `in` changes → `in_ready`=0 and `out` stable. Release `out_ready` → one drain with an accept in the same cycle, `out_valid` stays 1.
4. CHANNELS=5, direct mode, `sel`=6 → `out`=0, `out_err`=1, `out_ch`=6, `out_valid`=1.
5. Assert `rst_n` low mid-scan with `out_valid`=1 → outputs 0 immediately. After release, the first accept uses `sel` (S_DIRECT).
6. `MUX_N_REG_MASK_EN`, CHANNELS=8, `ch_mask`=8'b1001_0010, scan from `sel`=1 → `out_ch` sequence 1,4,7,1. Then `ch_mask`=0 → `in_ready`=0.
